evo_response_meter: RTL and testbench

//   Clocked stimulus/measurement harness for the evolved LCELL circuits under test.
//   - Drives the circuit's 2-bit input through all four vectors, 0..3.
//   - For each vector, waits a settle time, then samples the circuit's asynchronous

---
 rtl/evo_meter_pkg.sv | 16 +
 rtl/bit_synchronizer.sv | 26 ++
 rtl/evo_response_meter.sv | 163 ++++++++++++++++
 tb/tb_evo_response_meter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/evo_meter_pkg.sv
// Shared types and constants for the evolved-circuit response meter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package evo_meter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        MEASURE,
        REPORT
    } state_t;

    localparam int NUM_VECTORS = 4;
    localparam int VEC_W       = 2;

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer bringing an asynchronous bit into the clk domain.
// Latency: STAGES clk cycles from d to q.
// Backpressure: none; samples every cycle.
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain;

    // Shift the asynchronous input through the flop chain; cleared on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/evo_response_meter.sv
// Sweeps a 2-bit stimulus over 0..3 and measures edges/high-time/level of the response.
// Latency: SETTLE_CYCLES + WINDOW_CYCLES + 1 cycles per vector with res_ready held high.
// Backpressure: res_ready low holds the result and stalls the sweep; dut_in stays put.
module evo_response_meter
    import evo_meter_pkg::*;
#(
    parameter int SETTLE_CYCLES = 16,
    parameter int WINDOW_CYCLES = 1024,
    parameter int CNT_W         = 16,
    parameter int SYNC_STAGES   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [VEC_W-1:0] dut_in,
    input  logic             dut_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [VEC_W-1:0] res_vector,
    output logic [CNT_W-1:0] res_edges,
    output logic [CNT_W-1:0] res_high,
    output logic             res_level
);

    // One phase counter serves both the settle and the window intervals.
    localparam int PH_MAX = (SETTLE_CYCLES > WINDOW_CYCLES) ? SETTLE_CYCLES : WINDOW_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX) + 1;

    localparam logic [PH_W-1:0]  SETTLE_LAST = PH_W'(SETTLE_CYCLES - 1);
    localparam logic [PH_W-1:0]  WIN_LAST    = PH_W'(WINDOW_CYCLES - 1);
    localparam logic [VEC_W-1:0] LAST_VEC    = VEC_W'(NUM_VECTORS - 1);

    state_t            state_q;
    state_t            state_d;
    logic [PH_W-1:0]   ph_cnt;
    logic [VEC_W-1:0]  vec_q;
    logic              sample;
    logic              prev_sample;
    logic [CNT_W-1:0]  edges_q;
    logic [CNT_W-1:0]  high_q;
    logic [CNT_W-1:0]  edges_nx;
    logic [CNT_W-1:0]  high_nx;
    logic              settle_end;
    logic              win_end;
    logic              busy_q;
    logic              done_q;

    bit_synchronizer #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (dut_out),
        .q   (sample)
    );

    assign settle_end = (state_q == SETTLE)  && (ph_cnt == SETTLE_LAST);
    assign win_end    = (state_q == MEASURE) && (ph_cnt == WIN_LAST);

    // Saturating next values of the window counters for the current sample.
    always_comb begin
        edges_nx = edges_q;
        high_nx  = high_q;
        if (!prev_sample && sample && (edges_q != '1)) begin
            edges_nx = edges_q + CNT_W'(1);
        end
        if (sample && (high_q != '1)) begin
            high_nx = high_q + CNT_W'(1);
        end
    end

    // Next-state decode for the sweep sequencer.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)      state_d = SETTLE;
            SETTLE:  if (settle_end) state_d = MEASURE;
            MEASURE: if (win_end)    state_d = REPORT;
            REPORT:  if (res_ready)  state_d = (vec_q == LAST_VEC) ? IDLE : SETTLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Sweep datapath: vector, phase counter, window counters and the result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            ph_cnt      <= '0;
            vec_q       <= '0;
            prev_sample <= 1'b0;
            edges_q     <= '0;
            high_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            res_valid   <= 1'b0;
            res_vector  <= '0;
            res_edges   <= '0;
            res_high    <= '0;
            res_level   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        vec_q  <= '0;
                        busy_q <= 1'b1;
                        ph_cnt <= '0;
                    end
                end
                SETTLE: begin
                    ph_cnt <= settle_end ? '0 : ph_cnt + PH_W'(1);
                    if (settle_end) begin
                        prev_sample <= sample;
                        edges_q     <= '0;
                        high_q      <= '0;
                    end
                end
                MEASURE: begin
                    edges_q     <= edges_nx;
                    high_q      <= high_nx;
                    prev_sample <= sample;
                    ph_cnt      <= win_end ? '0 : ph_cnt + PH_W'(1);
                    if (win_end) begin
                        res_valid  <= 1'b1;
                        res_vector <= vec_q;
                        res_edges  <= edges_nx;
                        res_high   <= high_nx;
                        res_level  <= sample;
                    end
                end
                REPORT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        ph_cnt    <= '0;
                        if (vec_q == LAST_VEC) begin
                            vec_q  <= '0;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                        end else begin
                            vec_q <= vec_q + VEC_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign dut_in = vec_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_evo_response_meter.sv
module tb_evo_response_meter;

    localparam int S    = 16;
    localparam int W    = 64;
    localparam int MAXC = 8000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start, dut_out, res_ready;

    logic        a_busy, a_done, a_res_valid, a_res_level;
    logic [1:0]  a_dut_in, a_res_vector;
    logic [15:0] a_res_edges, a_res_high;

    logic        b_busy, b_done, b_res_valid, b_res_level;
    logic [1:0]  b_dut_in, b_res_vector;
    logic [3:0]  b_res_edges, b_res_high;

    evo_response_meter #(
        .SETTLE_CYCLES (S), .WINDOW_CYCLES (W), .CNT_W (16), .SYNC_STAGES (2)
    ) dut_a (
        .clk (clk), .rst (rst), .start (start), .busy (a_busy), .done (a_done),
        .dut_in (a_dut_in), .dut_out (dut_out), .res_valid (a_res_valid),
        .res_ready (res_ready), .res_vector (a_res_vector), .res_edges (a_res_edges),
        .res_high (a_res_high), .res_level (a_res_level)
    );

    evo_response_meter #(
        .SETTLE_CYCLES (S), .WINDOW_CYCLES (W), .CNT_W (4), .SYNC_STAGES (2)
    ) dut_b (
        .clk (clk), .rst (rst), .start (start), .busy (b_busy), .done (b_done),
        .dut_in (b_dut_in), .dut_out (dut_out), .res_valid (b_res_valid),
        .res_ready (res_ready), .res_vector (b_res_vector), .res_edges (b_res_edges),
        .res_high (b_res_high), .res_level (b_res_level)
    );

    int e        = 0;
    int ncmp     = 0;
    int nfail    = 0;
    int cur_mode = 0;
    int phase    = 0;
    int hold     = 0;
    bit lvl      = 1'b0;
    bit wave [MAXC];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        ncmp++;
        assert (obs === exp_v) else begin
            nfail++;
            $error("FAIL %s @edge %0d: observed %0d expected %0d", tag, e, obs, exp_v);
        end
    endtask

    // Response level driven after edge e, chosen by the current waveform mode.
    task automatic next_wave();
        bit w;
        case (cur_mode)
            0: w = 1'b0;
            1: w = 1'b1;
            2: w = (((e + phase) % 8) < 4);
            3: w = e[0];
            4: begin
                if (hold == 0) begin
                    lvl  = 1'($urandom % 2);
                    hold = $urandom_range(1, 12);
                end
                hold--;
                w = lvl;
            end
            default: w = 1'($urandom % 2);
        endcase
        wave[e] = w;
        dut_out = w;
    endtask

    task automatic step();
        @(posedge clk);
        e++;
        #1;
        if (e >= MAXC) begin
            $display("FAIL cycle_budget: observed edge %0d required below %0d", e, MAXC);
            $fatal(1, "cycle budget exhausted");
        end
        next_wave();
    endtask

    // Synchronized sample the meter sees at edge j: the level driven after edge j-3.
    function automatic int smp(input int j);
        return (j >= 3) ? int'(wave[j-3]) : 0;
    endfunction

    // Expected result for a window whose last cycle is edge k.
    task automatic model(input int k, input int cmax, output int ed, output int hi, output int lv);
        ed = 0;
        hi = 0;
        for (int j = k - W + 1; j <= k; j++) begin
            if (smp(j) == 1 && hi < cmax) hi++;
            if (smp(j - 1) == 0 && smp(j) == 1 && ed < cmax) ed++;
        end
        lv = smp(k);
    endtask

    task automatic chk_all(input string t, input int v, input int k, input bit bsy, input bit dn);
        bit vld;
        int ed, hi, lv;
        vld = (e >= k);
        chk({t, "_a_busy"},  32'(a_busy),      32'(bsy));
        chk({t, "_b_busy"},  32'(b_busy),      32'(bsy));
        chk({t, "_a_done"},  32'(a_done),      32'(dn));
        chk({t, "_b_done"},  32'(b_done),      32'(dn));
        chk({t, "_a_valid"}, 32'(a_res_valid), 32'(vld));
        chk({t, "_b_valid"}, 32'(b_res_valid), 32'(vld));
        chk({t, "_a_dut_in"}, 32'(a_dut_in),   32'(v));
        chk({t, "_b_dut_in"}, 32'(b_dut_in),   32'(v));
        if (vld) begin
            model(k, 65535, ed, hi, lv);
            chk($sformatf("%s_a_vector_v%0d", t, v), 32'(a_res_vector), 32'(v));
            chk($sformatf("%s_a_edges_v%0d", t, v),  32'(a_res_edges),  32'(ed));
            chk($sformatf("%s_a_high_v%0d", t, v),   32'(a_res_high),   32'(hi));
            chk($sformatf("%s_a_level_v%0d", t, v),  32'(a_res_level),  32'(lv));
            model(k, 15, ed, hi, lv);
            chk($sformatf("%s_b_vector_v%0d", t, v), 32'(b_res_vector), 32'(v));
            chk($sformatf("%s_b_edges_v%0d", t, v),  32'(b_res_edges),  32'(ed));
            chk($sformatf("%s_b_high_v%0d", t, v),   32'(b_res_high),   32'(hi));
            chk($sformatf("%s_b_level_v%0d", t, v),  32'(b_res_level),  32'(lv));
        end
    endtask

    task automatic chk_idle(input string t);
        chk({t, "_a_busy"},   32'(a_busy),      32'd0);
        chk({t, "_b_busy"},   32'(b_busy),      32'd0);
        chk({t, "_a_done"},   32'(a_done),      32'd0);
        chk({t, "_b_done"},   32'(b_done),      32'd0);
        chk({t, "_a_valid"},  32'(a_res_valid), 32'd0);
        chk({t, "_b_valid"},  32'(b_res_valid), 32'd0);
        chk({t, "_a_dut_in"}, 32'(a_dut_in),    32'd0);
        chk({t, "_b_dut_in"}, 32'(b_dut_in),    32'd0);
    endtask

    // One full sweep; stall_v holds ready low 100 cycles at that vector's result,
    // abort_v pulses reset in that vector's window, start_hold keeps start asserted.
    task automatic sweep(input string t, input int mode, input int stall_v, input int abort_v,
                         input bit rnd_rdy, input bit start_hold);
        int v, base, k, stalled;
        bit rdy, xfer;
        cur_mode  = mode;
        phase     = $urandom_range(0, 7);
        start     = 1'b1;
        res_ready = 1'b1;
        step();
        start   = start_hold;
        base    = e;
        v       = 0;
        k       = base + S + W;
        stalled = 0;
        chk_all({t, "_accept"}, v, k, 1'b1, 1'b0);
        while (v < 4) begin
            if (v == abort_v && e == base + S + 10) begin
                rst = 1'b1;
                step();
                rst = 1'b0;
                chk_idle({t, "_abort"});
                repeat (5) begin
                    step();
                    chk_idle({t, "_post_abort"});
                end
                return;
            end
            rdy = 1'b1;
            if (e >= k) begin
                if (v == stall_v && stalled < 100) begin
                    rdy = 1'b0;
                    stalled++;
                end else if (rnd_rdy) begin
                    rdy = (($urandom % 3) != 0);
                end
            end else if (rnd_rdy) begin
                rdy = 1'($urandom % 2);
            end
            res_ready = rdy;
            xfer = (e >= k) && rdy;
            step();
            if (xfer) begin
                v++;
                base = e;
                k    = base + S + W;
            end
            if (v < 4) chk_all(t, v, k, 1'b1, 1'b0);
        end
        chk({t, "_final_a_done"},  32'(a_done),      32'd1);
        chk({t, "_final_b_done"},  32'(b_done),      32'd1);
        chk({t, "_final_a_busy"},  32'(a_busy),      32'd0);
        chk({t, "_final_b_busy"},  32'(b_busy),      32'd0);
        chk({t, "_final_a_valid"}, 32'(a_res_valid), 32'd0);
        chk({t, "_final_a_dut_in"}, 32'(a_dut_in),   32'd0);
        start     = 1'b0;
        res_ready = 1'b1;
        step();
        chk_idle({t, "_after"});
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        res_ready = 1'b0;
        dut_out   = 1'b0;
        wave[0]   = 1'b0;
        repeat (3) step();
        chk_idle("reset");
        chk("reset_a_vector", 32'(a_res_vector), 32'd0);
        chk("reset_a_edges",  32'(a_res_edges),  32'd0);
        chk("reset_a_high",   32'(a_res_high),   32'd0);
        chk("reset_a_level",  32'(a_res_level),  32'd0);
        chk("reset_b_edges",  32'(b_res_edges),  32'd0);
        rst = 1'b0;
        step();
        chk_idle("idle");

        sweep("const0",  0, -1, -1, 1'b0, 1'b0);
        sweep("const1",  1, -1, -1, 1'b0, 1'b0);
        sweep("square",  2, -1, -1, 1'b0, 1'b0);
        sweep("toggle",  3, -1, -1, 1'b0, 1'b0);
        sweep("stall",   4,  1, -1, 1'b0, 1'b0);
        sweep("abort",   5, -1,  2, 1'b0, 1'b0);
        sweep("restart", 5, -1, -1, 1'b1, 1'b1);
        sweep("bursty",  4, -1, -1, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
